// File: rtl/inst_rom_arbiter.sv
// Shares the single-ported instruction ROM between instruction fetch and a data-side read port.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fetch priority with bounded data starvation.
module inst_rom_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam int   CW           = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic {PRI_IF, PRI_D} prio_t;

    prio_t         prio;
    prio_t         prio_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          if_eff;
    logic          d_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio     <= PRI_IF;
            wait_cnt <= '0;
        end else begin
            prio     <= prio_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        if_eff        = if_req & ~flush;
        if_gnt        = 1'b0;
        d_gnt         = 1'b0;
        d_first       = 1'b0;
        prio_next     = prio;
        wait_cnt_next = wait_cnt;
        rom_ce        = CHIP_DISABLE;
        rom_addr      = '0;

        // Grants are suppressed while reset is held so nothing is captured on the reset edge.
        if (!rst) begin
`ifdef ROM_ARB_RR_EN
            d_first = (prio == PRI_D);
`else
            // prio never leaves PRI_IF here, so only starvation hands data the win.
            d_first = (prio == PRI_D) || (wait_cnt == STARVE_LIM);
`endif
            if (if_eff && d_req) begin
                d_gnt  = d_first;
                if_gnt = ~d_first;
            end else begin
                if_gnt = if_eff;
                d_gnt  = d_req;
            end

`ifdef ROM_ARB_RR_EN
            if (if_gnt) begin
                prio_next = PRI_D;
            end else if (d_gnt) begin
                prio_next = PRI_IF;
            end
            wait_cnt_next = '0;
`else
            prio_next = PRI_IF;
            if (d_gnt || !d_req) begin
                wait_cnt_next = '0;
            end else if (wait_cnt != STARVE_LIM) begin
                wait_cnt_next = wait_cnt + CW'(1);
            end
`endif
        end

        if (if_gnt) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = if_addr;
        end else if (d_gnt) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = d_addr;
        end
    end

    // Response stage: ROM word returned to whichever port was granted on the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= rom_inst;
            end
            if (d_gnt) begin
                d_rdata <= rom_inst;
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomised and directed checks of inst_rom_arbiter against a cycle-level reference model.
module tb_inst_rom_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, d_req;
    logic [31:0] if_addr, d_addr;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, rom_ce;
    logic [31:0] if_rdata, d_rdata, rom_addr, rom_inst;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_wait;
    bit          m_next_d;
    bit          m_if_rv, m_d_rv;
    logic [31:0] m_if_rdata, m_d_rdata;
    bit          eg_if, eg_d;
    logic [31:0] e_addr;

    inst_rom_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h3401_0020;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'hDEAD_BEEF;

    function void model_reset();
        m_wait = 0; m_next_d = 0;
        m_if_rv = 0; m_d_rv = 0;
        m_if_rdata = '0; m_d_rdata = '0;
    endfunction

    // Expected grant from the spec rules and the current inputs.
    function void predict();
        bit ie;
        ie = if_req && !flush;
        eg_if = 0; eg_d = 0;
        if (!rst) begin
            if (ie && d_req) begin
`ifdef ROM_ARB_RR_EN
                eg_d = m_next_d;
`else
                eg_d = (m_wait >= SM);
`endif
                eg_if = !eg_d;
            end else begin
                eg_if = ie;
                eg_d  = d_req;
            end
        end
        e_addr = eg_if ? if_addr : (eg_d ? d_addr : 32'h0);
    endfunction

    // Called just after a rising edge, inputs still as they were at the edge.
    function void advance();
        if (rst) begin
            model_reset();
        end else begin
            m_if_rv = eg_if;
            m_d_rv  = eg_d;
            if (eg_if) m_if_rdata = rom_word(e_addr);
            if (eg_d)  m_d_rdata  = rom_word(e_addr);
            if (d_req && !eg_d) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
            else                m_wait = 0;
            if (eg_if)     m_next_d = 1;
            else if (eg_d) m_next_d = 0;
        end
    endfunction

    task automatic drive(input bit ir, input logic [31:0] ia, input bit fl,
                         input bit dr, input logic [31:0] da);
        if_req = ir; if_addr = ia; flush = fl; d_req = dr; d_addr = da;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); advance();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 32'h0000_0040, 0, 1, 32'h0000_0200);
        rst = 1'b1;
        @(negedge clk); #1;
        n_tests++; if ({if_gnt, d_gnt, rom_ce} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", {if_gnt, d_gnt, rom_ce}); end
        n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
        n_tests++; if ({if_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {if_rvalid, d_rvalid}); end
        n_tests++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, d_rdata); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_fetch_basic();
        drive(1, 32'h0000_0010, 0, 0, 0);
        #1; predict();
        n_tests++; if ({if_gnt, d_gnt, rom_ce} !== 3'b101) begin n_fail++; $display("FAIL fetch_gnt got %b want 101", {if_gnt, d_gnt, rom_ce}); end
        n_tests++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_rom_addr got %h want 00000010", rom_addr); end
        @(posedge clk); advance();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1; predict();
        n_tests++; if ({if_rvalid, d_rvalid} !== 2'b10) begin n_fail++; $display("FAIL fetch_rvalid got %b want 10", {if_rvalid, d_rvalid}); end
        n_tests++; if (if_rdata !== 32'h3401_0020) begin n_fail++; $display("FAIL fetch_rdata got %h want 34010020", if_rdata); end
        @(posedge clk); advance();
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit exp_d, prev_d;
        pulse_reset();
        prev_d = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h0000_1000 + 32'(4 * k), 0, 1, 32'h0000_0300 + 32'(k));
            #1; predict();
`ifdef ROM_ARB_RR_EN
            exp_d = (k % 2 == 1);
`else
            exp_d = (k % 5 == 4);
`endif
            n_tests++; if ({if_gnt, d_gnt} !== {!exp_d, exp_d}) begin n_fail++; $display("FAIL contend_gnt k=%0d got %b want %b", k, {if_gnt, d_gnt}, {!exp_d, exp_d}); end
            if (k > 0) begin
                n_tests++; if ({if_rvalid, d_rvalid} !== {!prev_d, prev_d}) begin n_fail++; $display("FAIL contend_rvalid k=%0d got %b want %b", k, {if_rvalid, d_rvalid}, {!prev_d, prev_d}); end
                n_tests++; if (d_rdata !== m_d_rdata) begin n_fail++; $display("FAIL contend_d_rdata k=%0d got %h want %h", k, d_rdata, m_d_rdata); end
            end
            prev_d = exp_d;
            @(posedge clk); advance();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk); predict(); advance();
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] held;
        held = m_if_rdata;
        drive(1, 32'h0000_0044, 1, 0, 0);
        #1; predict();
        n_tests++; if ({if_gnt, d_gnt, rom_ce} !== 3'b000) begin n_fail++; $display("FAIL flush_gnt got %b want 000", {if_gnt, d_gnt, rom_ce}); end
        n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL flush_rom_addr got %h want 0", rom_addr); end
        @(posedge clk); advance();
        @(negedge clk);
        // flush together with a data request: data granted; fetch grant scheduled last cycle is none
        drive(1, 32'h0000_0048, 1, 1, 32'h0000_0088);
        #1; predict();
        n_tests++; if (if_rvalid !== 1'b0 || if_rdata !== held) begin n_fail++; $display("FAIL flush_hold got %b/%h want 0/%h", if_rvalid, if_rdata, held); end
        n_tests++; if ({if_gnt, d_gnt} !== 2'b01 || rom_addr !== 32'h88) begin n_fail++; $display("FAIL flush_dgnt got %b/%h want 01/00000088", {if_gnt, d_gnt}, rom_addr); end
        @(posedge clk); advance();
        @(negedge clk);
        // fetch granted, then flush next cycle must not cancel the response
        drive(1, 32'h0000_0050, 0, 0, 0);
        @(posedge clk); predict(); advance();
        @(negedge clk);
        drive(1, 32'h0000_0054, 1, 0, 0);
        #1; predict();
        n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== rom_word(32'h50)) begin n_fail++; $display("FAIL flush_keep_rvalid got %b/%h want 1/%h", if_rvalid, if_rdata, rom_word(32'h50)); end
        @(posedge clk); advance();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit exp_d;
        drive(0, 0, 0, 1, 32'h0000_0104);
        #1; predict();
        n_tests++; if (d_gnt !== 1'b1 || rom_addr !== 32'h104) begin n_fail++; $display("FAIL mid_dgnt got %b/%h want 1/00000104", d_gnt, rom_addr); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if ({d_gnt, rom_ce, d_rdata} !== 34'h0) begin n_fail++; $display("FAIL mid_in_reset got %b/%b/%h want 0/0/0", d_gnt, rom_ce, d_rdata); end
        @(posedge clk); advance();
        #1 rst = 1'b0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        n_tests++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_after got %b/%h want 0/0", d_rvalid, d_rdata); end
        // wait counter must restart from zero after the reset
        for (int k = 0; k <= SM; k++) begin
            drive(1, 32'h0000_2000, 0, 1, 32'h0000_0104);
            #1; predict();
`ifdef ROM_ARB_RR_EN
            exp_d = (k % 2 == 1);
`else
            exp_d = (k == SM);
`endif
            n_tests++; if (d_gnt !== exp_d) begin n_fail++; $display("FAIL mid_wait k=%0d got %b want %b", k, d_gnt, exp_d); end
            @(posedge clk); advance();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0,
                  ($urandom % 3) != 0, $urandom);
            #1; predict();
            n_tests++; if ({if_gnt, d_gnt, rom_ce} !== {eg_if, eg_d, eg_if | eg_d}) begin n_fail++; $display("FAIL b2b_gnt k=%0d got %b want %b", k, {if_gnt, d_gnt, rom_ce}, {eg_if, eg_d, eg_if | eg_d}); end
            n_tests++; if (rom_addr !== e_addr) begin n_fail++; $display("FAIL b2b_addr k=%0d got %h want %h", k, rom_addr, e_addr); end
            n_tests++; if ({if_rvalid, d_rvalid} !== {m_if_rv, m_d_rv}) begin n_fail++; $display("FAIL b2b_rvalid k=%0d got %b want %b", k, {if_rvalid, d_rvalid}, {m_if_rv, m_d_rv}); end
            n_tests++; if ({if_rdata, d_rdata} !== {m_if_rdata, m_d_rdata}) begin n_fail++; $display("FAIL b2b_rdata k=%0d got %h/%h want %h/%h", k, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end
            @(posedge clk); advance();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_idle();
        logic [31:0] hi, hd;
        @(posedge clk); predict(); advance();
        @(negedge clk);
        hi = m_if_rdata; hd = m_d_rdata;
        for (int k = 0; k < 10; k++) begin
            drive(0, $urandom, 0, 0, $urandom);
            #1; predict();
            n_tests++; if ({rom_ce, rom_addr, if_gnt, d_gnt} !== 35'h0) begin n_fail++; $display("FAIL idle_rom k=%0d got %b/%h want 0/0", k, rom_ce, rom_addr); end
            n_tests++; if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== hi || d_rdata !== hd) begin n_fail++; $display("FAIL idle_hold k=%0d got %b %h/%h want 00 %h/%h", k, {if_rvalid, d_rvalid}, if_rdata, d_rdata, hi, hd); end
            @(posedge clk); advance();
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_fetch_basic();
        test_contention();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
